multicycle_dp: RTL and testbench

//  Parametrised multi-cycle MIPS-subset core: datapath plus FSM controller in one block.

---
 rtl/multicycle_dp.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_dp.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_dp.sv
// Multi-cycle MIPS-subset core (add/sub/and/or/slt, addi, lw, sw, beq; j when MCDP_JUMP_EN is defined).
// Latency: ALU 4 cycles, beq/j 3 cycles, lw/sw 4-5 cycles, each plus fetch/memory wait cycles.
// Backpressure: imem/dmem req held with stable addr/data until ack; any memory stall freezes the FSM.
module multicycle_dp #(
    parameter int               ADDR_W   = 32,
    parameter int               NREGS    = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              retire,
    output logic              trap,
    output logic [ADDR_W-1:0] pc_out
);
    localparam int IDX_W = $clog2(NREGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc, bt;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       regs [NREGS];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, wb_idx;
    logic [31:0]       simm, rs_val, rt_val, alu_res, wb_data;
    logic signed [31:0] br_off;
    logic              funct_ok, exec_legal;
    logic              unused_shamt;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign simm         = {{16{ir[15]}}, ir[15:0]};
    assign br_off       = {simm[29:0], 2'b00};
    assign pc_out       = pc;

`ifdef MCDP_JUMP_EN
    logic [ADDR_W-1:0] jump_pc;
    if (ADDR_W > 28) begin : g_jwide
        assign jump_pc = {pc[ADDR_W-1:28], ir[25:0], 2'b00};
    end else begin : g_jnarrow
        assign jump_pc = ADDR_W'({ir[25:0], 2'b00});
    end
`endif

    // Unimplemented register indices read as zero.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && 32'(rs) < NREGS) rs_val = regs[rs[IDX_W-1:0]];
        if (rt != 5'd0 && 32'(rt) < NREGS) rt_val = regs[rt[IDX_W-1:0]];
    end

    always_comb begin
        alu_res  = a + simm;
        funct_ok = 1'b0;
        if (opcode == OP_R) begin
            funct_ok = 1'b1;
            case (funct)
                6'h20:   alu_res = a + b;
                6'h22:   alu_res = a - b;
                6'h24:   alu_res = a & b;
                6'h25:   alu_res = a | b;
                6'h2A:   alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: funct_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        exec_legal = 1'b0;
        case (opcode)
            OP_R:                            exec_legal = funct_ok;
            OP_ADDI, OP_LW, OP_SW, OP_BEQ:   exec_legal = 1'b1;
`ifdef MCDP_JUMP_EN
            OP_J:                            exec_legal = 1'b1;
`endif
            default:                         exec_legal = 1'b0;
        endcase
    end

    always_comb begin
        wb_idx  = rd;
        wb_data = alu_out;
        if (opcode == OP_ADDI) wb_idx = rt;
        if (opcode == OP_LW) begin
            wb_idx  = rt;
            wb_data = mdr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= PC_RESET;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            bt         <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            trap       <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        ir       <= imem_rdata;
                        pc       <= pc + ADDR_W'(4);
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rs_val;
                    b     <= rt_val;
                    bt    <= pc + ADDR_W'(br_off);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!exec_legal) begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW: begin
                                alu_out <= alu_res;
                                if (alu_res[1:0] != 2'b00) begin
                                    trap  <= 1'b1;
                                    state <= S_TRAP;
                                end else begin
                                    dmem_req   <= 1'b1;
                                    dmem_we    <= (opcode == OP_SW);
                                    dmem_addr  <= ADDR_W'(alu_res);
                                    dmem_wdata <= b;
                                    state      <= S_MEM;
                                end
                            end
                            OP_BEQ: begin
                                if (a == b) pc <= bt;
                                retire <= 1'b1;
                                state  <= S_FETCH;
                            end
`ifdef MCDP_JUMP_EN
                            OP_J: begin
                                pc     <= jump_pc;
                                retire <= 1'b1;
                                state  <= S_FETCH;
                            end
`endif
                            default: begin
                                alu_out <= alu_res;
                                state   <= S_WB;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end else begin
                            mdr   <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0 && 32'(wb_idx) < NREGS) regs[wb_idx[IDX_W-1:0]] <= wb_data;
                    retire <= 1'b1;
                    state  <= S_FETCH;
                end
                default: begin
                    trap  <= 1'b1;
                    state <= S_TRAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_dp.sv
// Scoreboard bench: an ISA-level model executes each instruction as it is fetched and queues the
// expected retire pc/latency and data access; negedge monitors pop and compare against the core.
module tb_multicycle_dp;
    localparam int          ADDR_W = 32;
    localparam int          NREGS  = 24;
    localparam logic [31:0] PC_RST = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, trap;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

    multicycle_dp #(.ADDR_W(ADDR_W), .NREGS(NREGS), .PC_RESET(PC_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .trap(trap), .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] pc; int due; } ret_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dm_t;

    ret_t        ret_q[$];
    dm_t         dm_q[$];
    logic [31:0] prog_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [64];
    logic [31:0] env_mem [64];
    logic [31:0] m_pc;
    bit          m_trap, mon_en;
    int          checks, failures, dreq_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] i);
        if (i == 5'd0 || int'(i) >= NREGS) return 32'd0;
        return m_regs[i];
    endfunction

    task automatic m_wr(input logic [4:0] i, input logic [31:0] v);
        if (i != 5'd0 && int'(i) < NREGS) m_regs[i] = v;
    endtask

    task automatic model_reset();
        m_pc = PC_RST;
        m_trap = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // Architectural effect of one instruction; icyc is the cycle in which its fetch ack is driven.
    task automatic model_issue(input logic [31:0] ins, input int icyc);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] simm, a, b, npc, ea, res;
        ret_t        r;
        dm_t         d;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        simm = {{16{ins[15]}}, ins[15:0]};
        a = m_rd(rs); b = m_rd(rt);
        npc = m_pc + 32'd4;
        res = 32'd0;
        case (op)
            6'h00: begin
                case (ins[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin m_trap = 1'b1; return; end
                endcase
                m_wr(rd, res);
                r = '{npc, icyc + 4};
            end
            6'h08: begin
                m_wr(rt, a + simm);
                r = '{npc, icyc + 4};
            end
            6'h23, 6'h2B: begin
                ea = a + simm;
                if (ea[1:0] != 2'b00) begin m_trap = 1'b1; return; end
                d.we = (op == 6'h2B); d.addr = ea; d.wdata = b;
                dm_q.push_back(d);
                if (d.we) m_mem[ea[7:2]] = b;
                else      m_wr(rt, m_mem[ea[7:2]]);
                r = '{npc, 0};
            end
            6'h04: begin
                if (a == b) npc = npc + (simm << 2);
                r = '{npc, icyc + 3};
            end
`ifdef MCDP_JUMP_EN
            6'h02: begin
                npc = {npc[31:28], ins[25:0], 2'b00};
                r = '{npc, icyc + 3};
            end
`endif
            default: begin m_trap = 1'b1; return; end
        endcase
        ret_q.push_back(r);
        m_pc = npc;
    endtask

    function automatic logic [31:0] rand_ins();
        int          k;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        k  = $urandom_range(0, 9);
        rs = 5'($urandom_range(0, 31));
        rt = 5'($urandom_range(0, 31));
        rd = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        if (k <= 3) return enc_r(fn, rd, rs, rt);
        if (k <= 5) return enc_i(6'h08, rs, rt, 16'($urandom));
        if (k == 6) return enc_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
        if (k == 7) return enc_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
        if ($urandom_range(0, 1) == 1) rt = rs;
        return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 16) - 8));
    endfunction

    // Instruction memory: serves prog_q in order with 1-3 cycles of wait after req is seen.
    initial begin : imem_resp
        int          iw, tgt;
        logic [31:0] ins;
        iw = 0; tgt = 2;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            imem_ack = 1'b0;
            if (!rst_n || !imem_req) iw = 0;
            else if (prog_q.size() != 0) begin
                iw++;
                if (iw >= tgt) begin
                    ins = prog_q.pop_front();
                    if (m_trap) begin
                        checks++; failures++;
                        $display("FAIL fetch_after_trap actual=fetch at 0x%08h required=no fetch", imem_addr);
                    end
                    check("fetch_addr", imem_addr, m_pc);
                    imem_rdata = ins;
                    imem_ack = 1'b1;
                    model_issue(ins, cyc);
                    iw = 0;
                    tgt = $urandom_range(1, 3);
                end
            end
        end
    end

    // Data memory: acks after 2-4 cycles and checks the request stayed stable while waiting.
    initial begin : dmem_resp
        int          dw, tgt;
        logic [31:0] cap_addr, cap_wdata;
        dw = 0; tgt = 4; cap_addr = 32'd0; cap_wdata = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!rst_n || !dmem_req) dw = 0;
            else begin
                dw++;
                if (dw == 1) begin cap_addr = dmem_addr; cap_wdata = dmem_wdata; end
                if (dw >= tgt) begin
                    check("dmem_hold_addr", dmem_addr, cap_addr);
                    check("dmem_hold_wdata", dmem_wdata, cap_wdata);
                    if (dmem_we) env_mem[dmem_addr[7:2]] = dmem_wdata;
                    else         dmem_rdata = env_mem[dmem_addr[7:2]];
                    dmem_ack = 1'b1;
                    dw = 0;
                    tgt = $urandom_range(2, 4);
                end
            end
        end
    end

    initial begin : monitor
        ret_t r;
        dm_t  d;
        forever begin
            @(negedge clk);
            if (rst_n && dmem_req) dreq_cnt++;
            if (mon_en && rst_n) begin
                if (retire) begin
                    if (ret_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL retire_unexpected actual=retire pc_out=0x%08h required=no retire", pc_out);
                    end else begin
                        r = ret_q.pop_front();
                        check("retire_pc", pc_out, r.pc);
                        if (r.due != 0) check("retire_latency", 32'(cyc), 32'(r.due));
                    end
                end
                if (dmem_req && dmem_ack) begin
                    if (dm_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL dmem_unexpected actual=access at 0x%08h required=no access", dmem_addr);
                    end else begin
                        d = dm_q.pop_front();
                        check("dmem_we", 32'(dmem_we), 32'(d.we));
                        check("dmem_addr", dmem_addr, d.addr);
                        if (d.we) check("dmem_wdata", dmem_wdata, d.wdata);
                    end
                end
            end
        end
    end

    task automatic settle(input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && !trap && (prog_q.size() != 0 || ret_q.size() != 0 || dm_q.size() != 0)) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s actual=timeout after %0d cycles required=completion", name, n);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; mon_en = 1'b0;
        prog_q.delete(); ret_q.delete(); dm_q.delete();
        model_reset();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1'b1;
        dreq_cnt = 0;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0020;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        checks = 0; failures = 0; dreq_cnt = 0;
        rst_n = 1'b0; mon_en = 1'b0;
        model_reset();
        for (int i = 0; i < 64; i++) begin m_mem[i] = $urandom; env_mem[i] = m_mem[i]; end
        repeat (2) @(posedge clk); #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_pc", pc_out, PC_RST);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1; mon_en = 1'b1;

        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        prog_q.push_back(enc_r(6'h20, 5'd3, 5'd1, 5'd2));
        prog_q.push_back(enc_r(6'h2A, 5'd4, 5'd2, 5'd1));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd3, 16'd0));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd4, 16'd4));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd5, 16'd8));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd5, 16'd12));
        prog_q.push_back(enc_r(6'h20, 5'd0, 5'd1, 5'd1));
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd30, 16'd7));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd0, 16'd16));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd30, 16'd20));
        prog_q.push_back(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE));
        prog_q.push_back(enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE));
        for (int i = 0; i < 300; i++) prog_q.push_back(rand_ins());
        for (int i = 1; i < 32; i++) prog_q.push_back(enc_i(6'h2B, 5'd0, 5'(i), 16'(4 * i)));
        settle(20000, "drain_main");
        check("main_trap", 32'(trap), 32'(m_trap));

        // Misaligned load traps without touching data memory.
        apply_reset();
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd5, 16'd6));
        prog_q.push_back(NOP);
        settle(200, "misaligned");
        repeat (8) @(posedge clk); #1;
        check("misaligned_trap", 32'(trap), 32'(m_trap));
        check("misaligned_no_dmem", 32'(dreq_cnt), 32'd0);
        check("trap_no_imem_req", 32'(imem_req), 32'd0);

        apply_reset();
        prog_q.push_back(32'hFC00_0000);
        prog_q.push_back(NOP);
        settle(200, "bad_opcode");
        repeat (4) @(posedge clk); #1;
        check("bad_opcode_trap", 32'(trap), 32'd1);
        check("bad_opcode_model", 32'(trap), 32'(m_trap));

        apply_reset();
        prog_q.push_back({6'h02, 26'h100});
        prog_q.push_back(NOP);
        settle(200, "jump");
        #1;
`ifdef MCDP_JUMP_EN
        check("jump_trap", 32'(trap), 32'd0);
`else
        check("jump_trap", 32'(trap), 32'd1);
`endif
        check("jump_model", 32'(trap), 32'(m_trap));

        // Reset asserted while a fetch is outstanding.
        apply_reset();
        n = 0;
        while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
        check("midfetch_req_seen", 32'(imem_req), 32'd1);
        rst_n = 1'b0; mon_en = 1'b0;
        #1;
        check("midfetch_req_drop", 32'(imem_req), 32'd0);
        check("midfetch_pc", pc_out, PC_RST);
        model_reset();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1'b1;
        prog_q.push_back(enc_i(6'h08, 5'd0, 5'd7, 16'd9));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd7, 16'd0));
        settle(200, "midfetch_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
